// File: rtl/mips_pkg.sv
// Shared types and sizing for the MIPS register file and its read ports.
// Combinational helpers only; no state lives here.
// Every data path uses word_t so widths stay exactly DATA_W end to end.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int NREGS  = 32;

  typedef logic [DATA_W-1:0] word_t;
  typedef logic [ADDR_W-1:0] reg_addr_t;

  localparam reg_addr_t REG_ZERO = 5'd0;

endpackage

// File: rtl/rf_read_port.sv
// One register-file read port: $0 zero-detect, optional write forwarding, select.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the port always presents data for whatever address is driven.
module rf_read_port
  import mips_pkg::*;
#(
  parameter bit BYPASS = 1'b0
) (
  input  reg_addr_t addr,
  input  word_t     stored,
  input  logic      wr_en,
  input  reg_addr_t wr_addr,
  input  word_t     wr_data,
  output word_t     data
);

  logic is_zero;
  logic fwd_hit;

  // $0 always wins; a forwarding hit only exists when this instance was built with bypass
  always_comb begin
    is_zero = (addr == REG_ZERO);
    fwd_hit = BYPASS && wr_en && (wr_addr != REG_ZERO) && (wr_addr == addr);
    if (is_zero) begin
      data = '0;
    end else if (fwd_hit) begin
      data = wr_data;
    end else begin
      data = stored;
    end
  end

endmodule

// File: rtl/reg_file.sv
// MIPS 32x32 register file: two read ports, one write port, one debug read port.
// Latency: reads combinational, writes land on the rising edge; sync active-low reset.
// Backpressure: none. Build option RF_WRITE_BYPASS_EN forwards same-cycle writes to rd1/rd2.
module reg_file
  import mips_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  reg_addr_t ra1,
  input  reg_addr_t ra2,
  output word_t     rd1,
  output word_t     rd2,
  input  logic      we,
  input  reg_addr_t wa,
  input  word_t     wd,
  input  reg_addr_t dbg_addr,
  output word_t     dbg_data
);

`ifdef RF_WRITE_BYPASS_EN
  localparam bit RD_BYPASS = 1'b1;
`else
  localparam bit RD_BYPASS = 1'b0;
`endif

  word_t regs [NREGS];

  // Storage: reset clears everything and beats any simultaneous write; $0 is never written
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we && (wa != REG_ZERO)) begin
      regs[wa] <= wd;
    end
  end

  rf_read_port #(.BYPASS(RD_BYPASS)) u_rd1 (
    .addr    (ra1),
    .stored  (regs[ra1]),
    .wr_en   (we),
    .wr_addr (wa),
    .wr_data (wd),
    .data    (rd1)
  );

  rf_read_port #(.BYPASS(RD_BYPASS)) u_rd2 (
    .addr    (ra2),
    .stored  (regs[ra2]),
    .wr_en   (we),
    .wr_addr (wa),
    .wr_data (wd),
    .data    (rd2)
  );

  // Debug port shows committed state only, so forwarding is tied off
  rf_read_port #(.BYPASS(1'b0)) u_dbg (
    .addr    (dbg_addr),
    .stored  (regs[dbg_addr]),
    .wr_en   (1'b0),
    .wr_addr (REG_ZERO),
    .wr_data ('0),
    .data    (dbg_data)
  );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file against an array-based reference model.
// Works for both builds; forwarding expectations follow RF_WRITE_BYPASS_EN.
module tb_reg_file;

  logic        clk;
  logic        rst_n;
  logic [4:0]  ra1, ra2, wa, dbg_addr;
  logic [31:0] rd1, rd2, wd, dbg_data;
  logic        we;

  // ALU-source 2:1 mux downstream of the register file
  logic        mux_sel;
  logic [31:0] imm_sext;
  logic [31:0] mux_o;
  assign mux_o = mux_sel ? imm_sext : rd2;

  int checks   = 0;
  int failures = 0;

  logic [31:0] model [32];

`ifdef RF_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  reg_file dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected combinational read given the current model and pending write
  function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit fwd);
    if (a == 0) return 32'h0;
    if (fwd && BYP && we && rst_n !== 1'bx && wa == a) return wd;
    return model[a];
  endfunction

  // Advance one rising edge, apply the architectural update to the model, settle
  task automatic clk_edge();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (we && wa != 0) begin
      model[wa] = wd;
    end
    #1;
  endtask

  task automatic do_write(input logic [4:0] a, input logic [31:0] d);
    we = 1'b1; wa = a; wd = d;
    clk_edge();
    we = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; we = 1'b0; wa = 0; wd = 0; ra1 = 0; ra2 = 0; dbg_addr = 0;
    mux_sel = 1'b0; imm_sext = 32'h0;
    for (int i = 0; i < 32; i++) model[i] = 32'hx;
    clk_edge();
    rst_n = 1'b1;
    do_write(5'd5, 32'hDEADBEEF);
    ra1 = 5; #1;
    checks++;
    if (rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL reset_prewrite rd1=%h exp=%h", rd1, 32'hDEADBEEF);
    end
    rst_n = 1'b0; we = 1'b1; wa = 5; wd = 32'h1;
    clk_edge();
    rst_n = 1'b1; we = 1'b0;
    #1;
    checks++;
    if (rd1 !== 32'h0) begin
      failures++; $display("FAIL reset_r5 rd1=%h exp=0", rd1);
    end
    for (int i = 0; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = 5'(31 - i); dbg_addr = i[4:0]; #1;
      checks++;
      if (rd1 !== 0 || rd2 !== 0 || dbg_data !== 0) begin
        failures++; $display("FAIL reset_all a=%0d rd1=%h rd2=%h dbg=%h exp=0", i, rd1, rd2, dbg_data);
      end
    end
  endtask

  task automatic test_basic();
    do_write(5'd3, 32'h00000080);
    do_write(5'd31, 32'hFFFFFFFF);
    ra1 = 3; ra2 = 31; mux_sel = 1'b0; imm_sext = 32'h0000_1234; #1;
    checks++;
    if (rd1 !== 32'h80 || rd2 !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL basic rd1=%h rd2=%h exp=00000080/ffffffff", rd1, rd2);
    end
    checks++;
    if (mux_o !== 32'hFFFFFFFF) begin
      failures++; $display("FAIL basic_mux o=%h exp=ffffffff", mux_o);
    end
  endtask

  task automatic test_zero();
    we = 1'b1; wa = 0; wd = 32'h12345678; ra1 = 0; ra2 = 0; dbg_addr = 0; #1;
    checks++;
    if (rd1 !== 0 || rd2 !== 0 || dbg_data !== 0) begin
      failures++; $display("FAIL zero_before rd1=%h rd2=%h dbg=%h exp=0", rd1, rd2, dbg_data);
    end
    clk_edge();
    we = 1'b0; #1;
    checks++;
    if (rd1 !== 0 || rd2 !== 0 || dbg_data !== 0) begin
      failures++; $display("FAIL zero_after rd1=%h rd2=%h dbg=%h exp=0", rd1, rd2, dbg_data);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] exp_now;
    do_write(5'd7, 32'hA);
    we = 1'b1; wa = 7; wd = 32'hB; ra1 = 7; dbg_addr = 7; #1;
    exp_now = BYP ? 32'hB : 32'hA;
    checks++;
    if (rd1 !== exp_now) begin
      failures++; $display("FAIL same_cycle_rd1 rd1=%h exp=%h", rd1, exp_now);
    end
    checks++;
    if (dbg_data !== 32'hA) begin
      failures++; $display("FAIL same_cycle_dbg dbg=%h exp=0000000a", dbg_data);
    end
    clk_edge();
    we = 1'b0; #1;
    checks++;
    if (rd1 !== 32'hB || dbg_data !== 32'hB) begin
      failures++; $display("FAIL same_cycle_next rd1=%h dbg=%h exp=0000000b", rd1, dbg_data);
    end
  endtask

  task automatic test_we_gating();
    ra1 = 9; dbg_addr = 9;
    for (int k = 0; k < 3; k++) begin
      we = 1'b0; wa = 9; wd = 32'h55;
      clk_edge();
      checks++;
      if (rd1 !== 32'h0 || dbg_data !== 32'h0) begin
        failures++; $display("FAIL we_gating k=%0d rd1=%h dbg=%h exp=0", k, rd1, dbg_data);
      end
    end
  endtask

  task automatic test_sweep();
    for (int i = 1; i < 32; i++) do_write(i[4:0], i * 32'h01010101);
    for (int i = 1; i < 32; i++) begin
      ra1 = i[4:0]; ra2 = i[4:0]; dbg_addr = i[4:0]; #1;
      checks++;
      if (rd1 !== i * 32'h01010101 || rd2 !== i * 32'h01010101 || dbg_data !== i * 32'h01010101) begin
        failures++;
        $display("FAIL sweep a=%0d rd1=%h rd2=%h dbg=%h exp=%h", i, rd1, rd2, dbg_data, i * 32'h01010101);
      end
    end
  endtask

  task automatic test_random();
    logic [31:0] e1, e2, ed;
    for (int n = 0; n < 400; n++) begin
      rst_n    = ($urandom_range(0, 39) != 0);
      we       = $urandom_range(0, 1);
      wa       = 5'($urandom);
      wd       = $urandom;
      ra1      = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      ra2      = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      dbg_addr = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
      #1;
      e1 = exp_rd(ra1, 1'b1);
      e2 = exp_rd(ra2, 1'b1);
      ed = exp_rd(dbg_addr, 1'b0);
      checks++;
      if (rd1 !== e1 || rd2 !== e2 || dbg_data !== ed) begin
        failures++;
        $display("FAIL random n=%0d rd1=%h/%h rd2=%h/%h dbg=%h/%h", n, rd1, e1, rd2, e2, dbg_data, ed);
      end
      clk_edge();
    end
    rst_n = 1'b1; we = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_zero();
    test_same_cycle();
    test_we_gating();
    test_sweep();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
